elevator_request_scheduler: RTL and testbench

Parametrised floor-request scheduler for the elevator controller. Latches hall calls (up/down per floor) and cabin destination calls for `NFLOORS` floors into direction-split pending vectors. Runs a collective-SCAN policy that commands car motion and door cycles. It sits between the button/debounce front end and the motor/door sequencer, which reports floor arrivals and door completion back to it.

---
 rtl/elevator_request_scheduler_pkg.sv | 15 +
 rtl/elevator_request_scheduler_floor_mask_scan.sv | 29 ++
 rtl/elevator_request_scheduler.sv | 170 +++++++++++++++++
 tb/tb_elevator_request_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_request_scheduler_pkg.sv
// elevator_pkg: shared types and constants for the elevator request scheduler.
//   sched_state_t : scheduler FSM state (IDLE / MOVE / DOOR)
//   DIR_UP/DIR_DN : encoding of travel direction and hall-call direction
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } sched_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/elevator_request_scheduler_floor_mask_scan.sv
// floor_mask_scan: combinational scan of a pending-floor mask around the car.
//   pending   : OR of the up and down pending vectors
//   cur_floor : current car floor
//   any_above : some pending bit strictly above cur_floor
//   any_below : some pending bit strictly below cur_floor
//   at_cur    : pending bit set at cur_floor
module floor_mask_scan #(
    parameter int NFLOORS = 4,
    parameter int FW      = $clog2(NFLOORS)
) (
    input  logic [NFLOORS-1:0] pending,
    input  logic [FW-1:0]      cur_floor,
    output logic               any_above,
    output logic               any_below,
    output logic               at_cur
);

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        at_cur    = 1'b0;
        for (int i = 0; i < NFLOORS; i++) begin
            if (i > int'(cur_floor)) any_above = any_above | pending[i];
            if (i < int'(cur_floor)) any_below = any_below | pending[i];
            if (i == int'(cur_floor)) at_cur   = pending[i];
        end
    end

endmodule

// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler: latches hall and cabin calls into up/down
// pending vectors and runs a collective-SCAN policy driving car motion and
// door cycles.
//   clk, reset          : clock, asynchronous active-high reset
//   hall_valid/floor/dir: hall call strobe (dir 1 = up)
//   cab_valid/floor     : cabin destination strobe
//   cur_floor, arrive   : car position, arrival pulse from the sequencer
//   door_done           : door cycle finished pulse
//   move_req, move_dir  : travel command and direction (1 = up)
//   door_open_req       : open door at cur_floor
//   pending_up/dn       : latched stops per direction
//   busy                : scheduler not idle
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NFLOORS = 4,
    parameter int FW      = $clog2(NFLOORS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hall_valid,
    input  logic [FW-1:0]      hall_floor,
    input  logic               hall_dir,
    input  logic               cab_valid,
    input  logic [FW-1:0]      cab_floor,
    input  logic [FW-1:0]      cur_floor,
    input  logic               arrive,
    input  logic               door_done,
    output logic               move_req,
    output logic               move_dir,
    output logic               door_open_req,
    output logic [NFLOORS-1:0] pending_up,
    output logic [NFLOORS-1:0] pending_dn,
    output logic               busy
);

    sched_state_t        state_q, state_d;
    logic                dir_q, dir_d;
    logic [NFLOORS-1:0]  pending_up_q, pending_up_d;
    logic [NFLOORS-1:0]  pending_dn_q, pending_dn_d;
    logic                move_req_q, move_req_d;
    logic                move_dir_q, move_dir_d;
    logic                door_open_req_q, door_open_req_d;
    logic                busy_q, busy_d;

    logic [NFLOORS-1:0]  set_up, set_dn, clr_up, clr_dn;
    logic                hall_ok, cab_ok, call_at_cur;
    logic                any_above, any_below, at_cur;
    logic                ahead, stop;

    floor_mask_scan #(.NFLOORS(NFLOORS), .FW(FW)) u_scan (
        .pending   (pending_up_q | pending_dn_q),
        .cur_floor (cur_floor),
        .any_above (any_above),
        .any_below (any_below),
        .at_cur    (at_cur)
    );

    always_comb begin
        hall_ok     = hall_valid && (int'(hall_floor) < NFLOORS);
        cab_ok      = cab_valid && (int'(cab_floor) < NFLOORS);
        set_up      = '0;
        set_dn      = '0;
        clr_up      = '0;
        clr_dn      = '0;
        call_at_cur = 1'b0;

        // Up call at the top and down call at the bottom swap queues, since
        // the car can only leave those floors in the other direction.
        if (hall_ok) begin
            if (hall_floor == cur_floor) call_at_cur = 1'b1;
            else if ((hall_dir == DIR_UP && int'(hall_floor) != NFLOORS-1) ||
                     (hall_dir == DIR_DN && hall_floor == '0))
                set_up[hall_floor] = 1'b1;
            else
                set_dn[hall_floor] = 1'b1;
        end
        if (cab_ok) begin
            if (cab_floor > cur_floor)      set_up[cab_floor] = 1'b1;
            else if (cab_floor < cur_floor) set_dn[cab_floor] = 1'b1;
            else                            call_at_cur = 1'b1;
        end

        ahead = (dir_q == DIR_UP) ? any_above : any_below;
        stop  = (dir_q == DIR_UP)
              ? (pending_up_q[cur_floor] || (pending_dn_q[cur_floor] && !any_above))
              : (pending_dn_q[cur_floor] || (pending_up_q[cur_floor] && !any_below));

        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                // A fresh call at the car's floor just opens the door.
                if (call_at_cur) state_d = ST_DOOR;
                else if (any_above && (dir_q == DIR_UP || !any_below)) begin
                    dir_d   = DIR_UP;
                    state_d = ST_MOVE;
                end else if (any_below) begin
                    dir_d   = DIR_DN;
                    state_d = ST_MOVE;
                end else if (at_cur) begin
                    clr_up[cur_floor] = 1'b1;
                    clr_dn[cur_floor] = 1'b1;
                    state_d = ST_DOOR;
                end
            end
            ST_MOVE: begin
                // The car is already leaving this floor: serve it on the way back.
                if (call_at_cur) begin
                    if (dir_q == DIR_UP) set_dn[cur_floor] = 1'b1;
                    else                 set_up[cur_floor] = 1'b1;
                end
                if (arrive) begin
                    if (stop) begin
                        if (dir_q == DIR_UP) clr_up[cur_floor] = 1'b1;
                        else                 clr_dn[cur_floor] = 1'b1;
                        if (!ahead) begin
                            clr_up[cur_floor] = 1'b1;
                            clr_dn[cur_floor] = 1'b1;
                            dir_d = ~dir_q;
                        end
                        state_d = ST_DOOR;
                    end else if (!ahead) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DOOR: if (door_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Clear beats set for the same bit in the same cycle.
        pending_up_d    = (pending_up_q | set_up) & ~clr_up;
        pending_dn_d    = (pending_dn_q | set_dn) & ~clr_dn;
        move_req_d      = (state_d == ST_MOVE);
        move_dir_d      = (state_d == ST_MOVE) && dir_d;
        door_open_req_d = (state_d == ST_DOOR);
        busy_d          = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            dir_q           <= DIR_UP;
            pending_up_q    <= '0;
            pending_dn_q    <= '0;
            move_req_q      <= 1'b0;
            move_dir_q      <= 1'b0;
            door_open_req_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            dir_q           <= dir_d;
            pending_up_q    <= pending_up_d;
            pending_dn_q    <= pending_dn_d;
            move_req_q      <= move_req_d;
            move_dir_q      <= move_dir_d;
            door_open_req_q <= door_open_req_d;
            busy_q          <= busy_d;
        end
    end

    assign move_req      = move_req_q;
    assign move_dir      = move_dir_q;
    assign door_open_req = door_open_req_q;
    assign pending_up    = pending_up_q;
    assign pending_dn    = pending_dn_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler: a 4-floor instance for the
// scheduling scenarios and a 5-floor instance for out-of-range floor values.
module tb_elevator_request_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hall_valid = 1'b0, hall_dir = 1'b0, cab_valid = 1'b0;
    logic [1:0] hall_floor = '0, cab_floor = '0, cur_floor = '0;
    logic       arrive = 1'b0, door_done = 1'b0;
    logic       move_req, move_dir, door_open_req, busy;
    logic [3:0] pending_up, pending_dn;

    logic       h2_valid = 1'b0, h2_dir = 1'b0, c2_valid = 1'b0;
    logic [2:0] h2_floor = '0, c2_floor = '0, cur2 = '0;
    logic       mreq2, mdir2, dopen2, busy2;
    logic [4:0] p2_up, p2_dn;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    elevator_request_scheduler #(.NFLOORS(4)) dut (
        .clk(clk), .reset(reset),
        .hall_valid(hall_valid), .hall_floor(hall_floor), .hall_dir(hall_dir),
        .cab_valid(cab_valid), .cab_floor(cab_floor),
        .cur_floor(cur_floor), .arrive(arrive), .door_done(door_done),
        .move_req(move_req), .move_dir(move_dir), .door_open_req(door_open_req),
        .pending_up(pending_up), .pending_dn(pending_dn), .busy(busy)
    );

    elevator_request_scheduler #(.NFLOORS(5)) dut5 (
        .clk(clk), .reset(reset),
        .hall_valid(h2_valid), .hall_floor(h2_floor), .hall_dir(h2_dir),
        .cab_valid(c2_valid), .cab_floor(c2_floor),
        .cur_floor(cur2), .arrive(1'b0), .door_done(1'b0),
        .move_req(mreq2), .move_dir(mdir2), .door_open_req(dopen2),
        .pending_up(p2_up), .pending_dn(p2_dn), .busy(busy2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        hall_valid = 1'b0; cab_valid = 1'b0; arrive = 1'b0; door_done = 1'b0;
        cur_floor = 2'd0;
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic hall(input int f, input logic d);
        hall_valid = 1'b1; hall_floor = 2'(f); hall_dir = d;
        tick;
        hall_valid = 1'b0;
    endtask

    task automatic cab(input int f);
        cab_valid = 1'b1; cab_floor = 2'(f);
        tick;
        cab_valid = 1'b0;
    endtask

    task automatic arr(input int f);
        cur_floor = 2'(f); arrive = 1'b1;
        tick;
        arrive = 1'b0;
    endtask

    task automatic door;
        door_done = 1'b1;
        tick;
        door_done = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        checks++; if ({move_req, move_dir, door_open_req, busy} !== 4'b0000) begin errors++; $display("FAIL reset_outputs: got %b expected 0000", {move_req, move_dir, door_open_req, busy}); end
        checks++; if ({pending_up, pending_dn} !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h expected 00", {pending_up, pending_dn}); end
        reset = 1'b0;
        tick;
        checks++; if ({move_req, busy} !== 2'b00) begin errors++; $display("FAIL idle_after_reset: got %b expected 00", {move_req, busy}); end
    endtask

    task automatic test_single_call;
        do_reset;
        hall(2, 1'b1);
        checks++; if (pending_up !== 4'b0100) begin errors++; $display("FAIL single_latch: got %b expected 0100", pending_up); end
        checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL single_latency1: got %b expected 0", move_req); end
        tick;
        checks++; if ({move_req, move_dir, busy} !== 3'b111) begin errors++; $display("FAIL single_move: got %b expected 111", {move_req, move_dir, busy}); end
        arr(1);
        checks++; if ({move_req, door_open_req} !== 2'b10) begin errors++; $display("FAIL single_pass1: got %b expected 10", {move_req, door_open_req}); end
        arr(2);
        checks++; if ({move_req, door_open_req} !== 2'b01) begin errors++; $display("FAIL single_stop: got %b expected 01", {move_req, door_open_req}); end
        checks++; if (pending_up !== 4'b0000) begin errors++; $display("FAIL single_clear: got %b expected 0000", pending_up); end
        door;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", busy); end
    endtask

    task automatic test_collective;
        do_reset;
        cab(3);
        tick;
        checks++; if ({move_req, move_dir} !== 2'b11) begin errors++; $display("FAIL coll_move_up: got %b expected 11", {move_req, move_dir}); end
        hall(1, 1'b0);
        checks++; if (pending_dn !== 4'b0010) begin errors++; $display("FAIL coll_latch_dn: got %b expected 0010", pending_dn); end
        arr(1);
        checks++; if ({move_req, door_open_req} !== 2'b10) begin errors++; $display("FAIL coll_pass1: got %b expected 10", {move_req, door_open_req}); end
        arr(2);
        arr(3);
        checks++; if ({door_open_req, pending_up, pending_dn} !== 9'b1_0000_0010) begin errors++; $display("FAIL coll_stop3: got %b expected 100000010", {door_open_req, pending_up, pending_dn}); end
        door;
        tick;
        checks++; if ({move_req, move_dir} !== 2'b10) begin errors++; $display("FAIL coll_move_dn: got %b expected 10", {move_req, move_dir}); end
        arr(2);
        arr(1);
        checks++; if ({door_open_req, pending_up, pending_dn} !== 9'b1_0000_0000) begin errors++; $display("FAIL coll_stop1: got %b expected 100000000", {door_open_req, pending_up, pending_dn}); end
        door;
    endtask

    task automatic test_pass_reverse;
        do_reset;
        cab(3);
        tick;
        hall(2, 1'b0);
        checks++; if (pending_dn !== 4'b0100) begin errors++; $display("FAIL rev_latch: got %b expected 0100", pending_dn); end
        arr(1);
        arr(2);
        checks++; if ({move_req, door_open_req} !== 2'b10) begin errors++; $display("FAIL rev_pass2: got %b expected 10", {move_req, door_open_req}); end
        arr(3);
        checks++; if ({door_open_req, pending_up, pending_dn} !== 9'b1_0000_0100) begin errors++; $display("FAIL rev_stop3: got %b expected 100000100", {door_open_req, pending_up, pending_dn}); end
        door;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rev_idle: got %b expected 0", busy); end
        tick;
        checks++; if ({move_req, move_dir} !== 2'b10) begin errors++; $display("FAIL rev_move_dn: got %b expected 10", {move_req, move_dir}); end
        arr(2);
        checks++; if ({door_open_req, pending_dn} !== 5'b1_0000) begin errors++; $display("FAIL rev_stop2: got %b expected 10000", {door_open_req, pending_dn}); end
        door;
    endtask

    task automatic test_call_at_cur;
        do_reset;
        cur_floor = 2'd1;
        hall(1, 1'b1);
        checks++; if ({door_open_req, move_req} !== 2'b10) begin errors++; $display("FAIL cur_door: got %b expected 10", {door_open_req, move_req}); end
        checks++; if ({pending_up, pending_dn} !== 8'h00) begin errors++; $display("FAIL cur_nolatch: got %h expected 00", {pending_up, pending_dn}); end
        hall(1, 1'b1);
        checks++; if ({door_open_req, pending_up, pending_dn} !== 9'b1_0000_0000) begin errors++; $display("FAIL cur_absorb: got %b expected 100000000", {door_open_req, pending_up, pending_dn}); end
        door;
        checks++; if ({busy, door_open_req} !== 2'b00) begin errors++; $display("FAIL cur_done: got %b expected 00", {busy, door_open_req}); end
        tick;
        checks++; if ({busy, move_req, door_open_req} !== 3'b000) begin errors++; $display("FAIL cur_stay_idle: got %b expected 000", {busy, move_req, door_open_req}); end
    endtask

    task automatic test_boundary_map;
        do_reset;
        cur_floor = 2'd1;
        hall(0, 1'b0);
        checks++; if ({pending_up, pending_dn} !== 8'b0001_0000) begin errors++; $display("FAIL map_dn0: got %b expected 00010000", {pending_up, pending_dn}); end
        hall(3, 1'b1);
        checks++; if (pending_dn !== 4'b1000) begin errors++; $display("FAIL map_up3: got %b expected 1000", pending_dn); end
        checks++; if ({move_req, move_dir} !== 2'b10) begin errors++; $display("FAIL map_move_dn: got %b expected 10", {move_req, move_dir}); end
        arr(0);
        checks++; if ({door_open_req, pending_up, pending_dn} !== 9'b1_0000_1000) begin errors++; $display("FAIL map_stop0: got %b expected 100001000", {door_open_req, pending_up, pending_dn}); end
    endtask

    task automatic test_out_of_range;
        do_reset;
        h2_valid = 1'b1; h2_floor = 3'd5; h2_dir = 1'b1;
        tick;
        h2_floor = 3'd6; h2_dir = 1'b0; c2_valid = 1'b1; c2_floor = 3'd7;
        tick;
        h2_valid = 1'b0; c2_valid = 1'b0;
        checks++; if ({p2_up, p2_dn} !== 10'b0) begin errors++; $display("FAIL oor_ignored: got %b expected 0000000000", {p2_up, p2_dn}); end
        tick;
        checks++; if ({busy2, mreq2, dopen2} !== 3'b000) begin errors++; $display("FAIL oor_idle: got %b expected 000", {busy2, mreq2, dopen2}); end
        h2_valid = 1'b1; h2_floor = 3'd4; h2_dir = 1'b1;
        tick;
        h2_valid = 1'b0;
        checks++; if ({p2_up, p2_dn} !== 10'b00000_10000) begin errors++; $display("FAIL top_up_map5: got %b expected 0000010000", {p2_up, p2_dn}); end
    endtask

    task automatic test_reset_mid_move;
        do_reset;
        hall_valid = 1'b1; hall_floor = 2'd1; hall_dir = 1'b1;
        cab_valid = 1'b1; cab_floor = 2'd2;
        tick;
        hall_valid = 1'b0; cab_valid = 1'b0;
        checks++; if ({pending_up, pending_dn} !== 8'b0110_0000) begin errors++; $display("FAIL both_calls: got %b expected 01100000", {pending_up, pending_dn}); end
        cab(3);
        checks++; if ({move_req, pending_up} !== 5'b1_1110) begin errors++; $display("FAIL mid_move_setup: got %b expected 11110", {move_req, pending_up}); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({move_req, move_dir, door_open_req, busy} !== 4'b0000) begin errors++; $display("FAIL async_reset_out: got %b expected 0000", {move_req, move_dir, door_open_req, busy}); end
        checks++; if ({pending_up, pending_dn} !== 8'h00) begin errors++; $display("FAIL async_reset_pend: got %h expected 00", {pending_up, pending_dn}); end
        tick;
        reset = 1'b0;
        tick;
        checks++; if ({busy, move_req} !== 2'b00) begin errors++; $display("FAIL post_reset_idle: got %b expected 00", {busy, move_req}); end
    endtask

    initial begin
        test_reset;
        test_single_call;
        test_collective;
        test_pass_reverse;
        test_call_at_cur;
        test_boundary_map;
        test_out_of_range;
        test_reset_mid_move;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
